// File: rtl/timer_counter0.sv
// ----------------------------------------------------------------------------
// timer_counter0 : 8-bit Timer/Counter0 for the ATmega32A emulator.
//
// Decodes CPU I/O writes to TCNT0, OCR0, TCCR0, TIMSK[1:0] and TIFR[1:0],
// runs a 10-bit prescaler and the 8-bit counter (normal or CTC mode), and
// raises the overflow and compare-match interrupt requests.
//
// Ports:
//   clk          in   system clock
//   clr          in   synchronous active-high reset
//   io_addr      in   6-bit I/O address from the CPU
//   io_wr        in   one-cycle I/O write strobe
//   io_din       in   8-bit I/O write data
//   io_dout      out  combinational read data for io_addr (8'h00 if not owned)
//   irq_ack_ov   in   TIMER0_OVF vector taken, clears TOV0
//   irq_ack_comp in   TIMER0_COMP vector taken, clears OCF0
//   irq_ov       out  TOV0 & TOIE0
//   irq_comp     out  OCF0 & OCIE0
//
// There is no FSM here; all state lives in the *_q register bank below.
// ----------------------------------------------------------------------------
module timer_counter0 #(
    parameter logic [5:0] IO_TCNT0 = 6'h32,
    parameter logic [5:0] IO_TCCR0 = 6'h33,
    parameter logic [5:0] IO_OCR0  = 6'h3C,
    parameter logic [5:0] IO_TIMSK = 6'h39,
    parameter logic [5:0] IO_TIFR  = 6'h38
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [5:0] io_addr,
    input  logic       io_wr,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    input  logic       irq_ack_ov,
    input  logic       irq_ack_comp,
    output logic       irq_ov,
    output logic       irq_comp
);

    // Register bank. tifr bit 0 = TOV0, bit 1 = OCF0; timsk likewise.
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] ocr_q, ocr_d;
    logic [7:0] tccr_q, tccr_d;
    logic [1:0] timsk_q, timsk_d;
    logic [1:0] tifr_q, tifr_d;
    logic [9:0] presc_q, presc_d;
    // Set by a TCNT0 write; blocks the compare match on the next tick.
    logic       supp_q, supp_d;

    logic running;
    logic tick;
    logic ctc;
    logic wr_tcnt, wr_ocr, wr_tccr, wr_timsk, wr_tifr;
    logic cnt_tick;
    logic match;
    logic set_tov, set_ocf;
    logic clr_tov, clr_ocf;

    // Clock select: the tick fires when the low log2(N) prescaler bits are
    // all ones. External-clock selections (110/111) are treated as stopped.
    always_comb begin
        running = 1'b0;
        tick    = 1'b0;
        case (tccr_q[2:0])
            3'd1: begin running = 1'b1; tick = 1'b1;           end
            3'd2: begin running = 1'b1; tick = &presc_q[2:0];  end
            3'd3: begin running = 1'b1; tick = &presc_q[5:0];  end
            3'd4: begin running = 1'b1; tick = &presc_q[7:0];  end
            3'd5: begin running = 1'b1; tick = &presc_q[9:0];  end
            default: begin running = 1'b0; tick = 1'b0;        end
        endcase
    end

    always_comb begin
        wr_tcnt  = io_wr && (io_addr == IO_TCNT0);
        wr_ocr   = io_wr && (io_addr == IO_OCR0);
        wr_tccr  = io_wr && (io_addr == IO_TCCR0);
        wr_timsk = io_wr && (io_addr == IO_TIMSK);
        wr_tifr  = io_wr && (io_addr == IO_TIFR);

        // CTC only for {WGM01,WGM00} = 2'b10; PWM encodings count as normal.
        ctc = tccr_q[3] & ~tccr_q[6];

        // A TCNT0 write discards the tick of the same cycle.
        cnt_tick = tick & ~wr_tcnt;
        // The suppressed match also blocks the CTC clear, not just OCF0.
        match    = cnt_tick & ~supp_q & (tcnt_q == ocr_q);
        set_ocf  = match;
        // Both modes leave 8'hFF by going to 8'h00, so TOV0 follows FF alone.
        set_tov  = cnt_tick & (tcnt_q == 8'hFF);

        // Writing TCCR0 deliberately leaves the prescaler running on.
        presc_d = running ? presc_q + 10'd1 : presc_q;

        tcnt_d = tcnt_q;
        supp_d = supp_q;
        if (wr_tcnt) begin
            tcnt_d = io_din;
            supp_d = 1'b1;
        end else if (cnt_tick) begin
            supp_d = 1'b0;
            tcnt_d = (ctc && match) ? 8'h00 : tcnt_q + 8'd1;
        end

        ocr_d   = wr_ocr   ? io_din      : ocr_q;
        tccr_d  = wr_tccr  ? io_din      : tccr_q;
        timsk_d = wr_timsk ? io_din[1:0] : timsk_q;

        // Flag priority: hardware set beats CPU clear/ack, which beats hold.
        clr_tov   = irq_ack_ov   | (wr_tifr & io_din[0]);
        clr_ocf   = irq_ack_comp | (wr_tifr & io_din[1]);
        tifr_d[0] = set_tov | (tifr_q[0] & ~clr_tov);
        tifr_d[1] = set_ocf | (tifr_q[1] & ~clr_ocf);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            tcnt_q  <= 8'h00;
            ocr_q   <= 8'h00;
            tccr_q  <= 8'h00;
            timsk_q <= 2'b00;
            tifr_q  <= 2'b00;
            presc_q <= 10'd0;
            supp_q  <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            ocr_q   <= ocr_d;
            tccr_q  <= tccr_d;
            timsk_q <= timsk_d;
            tifr_q  <= tifr_d;
            presc_q <= presc_d;
            supp_q  <= supp_d;
        end
    end

    always_comb begin
        io_dout = 8'h00;
        if (io_addr == IO_TCNT0)      io_dout = tcnt_q;
        else if (io_addr == IO_OCR0)  io_dout = ocr_q;
        else if (io_addr == IO_TCCR0) io_dout = tccr_q;
        else if (io_addr == IO_TIMSK) io_dout = {6'b0, timsk_q};
        else if (io_addr == IO_TIFR)  io_dout = {6'b0, tifr_q};
    end

    assign irq_ov   = tifr_q[0] & timsk_q[0];
    assign irq_comp = tifr_q[1] & timsk_q[1];

endmodule

// File: tb/tb_timer_counter0.sv
// ----------------------------------------------------------------------------
// tb_timer_counter0 : randomized and directed stimulus against a behavioural
// model of Timer/Counter0. The driver steps the model and queues the expected
// {io_addr, io_dout, irq_ov, irq_comp} for each cycle; the monitor pops one
// entry one time unit after every rising edge and compares.
// ----------------------------------------------------------------------------
module tb_timer_counter0;

    localparam logic [5:0] A_TCNT0 = 6'h32;
    localparam logic [5:0] A_TCCR0 = 6'h33;
    localparam logic [5:0] A_OCR0  = 6'h3C;
    localparam logic [5:0] A_TIMSK = 6'h39;
    localparam logic [5:0] A_TIFR  = 6'h38;
    localparam logic [5:0] A_NONE  = 6'h15;
    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] io_addr = 6'h00;
    logic       io_wr = 1'b0;
    logic [7:0] io_din = 8'h00;
    logic [7:0] io_dout;
    logic       irq_ack_ov = 1'b0;
    logic       irq_ack_comp = 1'b0;
    logic       irq_ov;
    logic       irq_comp;

    always #5 clk = ~clk;

    timer_counter0 dut (
        .clk          (clk),
        .clr          (clr),
        .io_addr      (io_addr),
        .io_wr        (io_wr),
        .io_din       (io_din),
        .io_dout      (io_dout),
        .irq_ack_ov   (irq_ack_ov),
        .irq_ack_comp (irq_ack_comp),
        .irq_ov       (irq_ov),
        .irq_comp     (irq_comp)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- behavioural model ----------------
    // Prescaler kept as a plain count modulo 1024; a tick is the cycle on
    // which the count reaches a multiple of the division ratio.
    int m_tcnt, m_ocr, m_tccr, m_timsk, m_presc;
    bit m_tov, m_ocf, m_supp;

    function automatic int ratio(input int cs);
        case (cs)
            1: return 1;
            2: return 8;
            3: return 64;
            4: return 256;
            5: return 1024;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] m_read(input logic [5:0] a);
        case (a)
            A_TCNT0: return 8'(m_tcnt);
            A_OCR0:  return 8'(m_ocr);
            A_TCCR0: return 8'(m_tccr);
            A_TIMSK: return 8'(m_timsk);
            A_TIFR:  return {6'b0, m_ocf, m_tov};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input bit c, input logic [5:0] a, input bit w,
                              input int d, input bit ao, input bit ac);
        int n;
        bit tick, ctc, match, s_tov, s_ocf;
        if (c) begin
            m_tcnt = 0; m_ocr = 0; m_tccr = 0; m_timsk = 0; m_presc = 0;
            m_tov = 0; m_ocf = 0; m_supp = 0;
            return;
        end
        n = ratio(m_tccr % 8);
        tick = 0;
        if (n != 0) begin
            tick = ((m_presc + 1) % n) == 0;
            m_presc = (m_presc + 1) % 1024;
        end
        ctc = ((m_tccr / 8) % 2 == 1) && ((m_tccr / 64) % 2 == 0);
        s_tov = 0;
        s_ocf = 0;
        if (w && a == A_TCNT0) begin
            m_tcnt = d;
            m_supp = 1;
        end else if (tick) begin
            match = (m_tcnt == m_ocr) && !m_supp;
            m_supp = 0;
            s_ocf = match;
            s_tov = (m_tcnt == 255);
            if (ctc && match) m_tcnt = 0;
            else m_tcnt = (m_tcnt + 1) % 256;
        end
        if (w && a == A_OCR0)  m_ocr = d;
        if (w && a == A_TCCR0) m_tccr = d;
        if (w && a == A_TIMSK) m_timsk = d % 4;
        if (s_tov) m_tov = 1;
        else if (ao || (w && a == A_TIFR && d % 2 == 1)) m_tov = 0;
        if (s_ocf) m_ocf = 1;
        else if (ac || (w && a == A_TIFR && (d / 2) % 2 == 1)) m_ocf = 0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit c, input logic [5:0] a, input bit w,
                         input logic [7:0] d, input bit ao, input bit ac);
        logic [7:0] e_dout;
        bit e_ov, e_comp;
        @(negedge clk);
        clr = c;
        io_addr = a;
        io_wr = w;
        io_din = d;
        irq_ack_ov = ao;
        irq_ack_comp = ac;
        model_step(c, a, w, int'(d), ao, ac);
        e_dout = m_read(a);
        e_ov = m_tov && (m_timsk % 2 == 1);
        e_comp = m_ocf && ((m_timsk / 2) % 2 == 1);
        exp_q.push_back({a, e_dout, e_ov, e_comp});
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        drive(1'b0, a, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [5:0] a);
        drive(1'b0, a, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic reset_cycle();
        drive(1'b1, A_TCNT0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (io_dout !== e[9:2]) begin
                errors++;
                $display("FAIL dout addr=%h got=%h exp=%h t=%0t", e[15:10], io_dout, e[9:2], $time);
            end
            checks++;
            if ({irq_ov, irq_comp} !== e[1:0]) begin
                errors++;
                $display("FAIL irq {ov,comp} got=%b%b exp=%b t=%0t", irq_ov, irq_comp, e[1:0], $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] addrs[6];

    initial begin
        addrs = '{A_TCNT0, A_TCCR0, A_OCR0, A_TIMSK, A_TIFR, A_NONE};

        // Reset, then every address reads zero.
        reset_cycle();
        for (int i = 0; i < 6; i++) rd(addrs[i]);

        // Normal /1 overflow, then acknowledge.
        wr(A_TCCR0, 8'h01);
        wr(A_TIMSK, 8'h01);
        wr(A_TCNT0, 8'hFD);
        for (int i = 0; i < 4; i++) rd(A_TCNT0);
        rd(A_TIFR);
        drive(1'b0, A_TIFR, 1'b0, 8'h00, 1'b1, 1'b0);
        rd(A_TIFR);

        // CTC at /8 with OCR0 = 5: 48-clock period, no overflow.
        wr(A_TIFR, 8'h03);
        wr(A_OCR0, 8'h05);
        wr(A_TIMSK, 8'h03);
        wr(A_TCCR0, 8'h0A);
        wr(A_TCNT0, 8'h00);
        for (int i = 0; i < 150; i++) begin
            rd((i % 3 == 0) ? A_TIFR : A_TCNT0);
            if (i % 50 == 49) wr(A_TIFR, 8'h02);
        end

        // Match suppressed right after a TCNT0 write equal to OCR0.
        wr(A_TCCR0, 8'h01);
        wr(A_TIFR, 8'h03);
        wr(A_OCR0, 8'h10);
        wr(A_TCNT0, 8'h10);
        for (int i = 0; i < 270; i++) rd((i % 2 == 0) ? A_TIFR : A_TCNT0);

        // Hardware set of OCF0 in the same cycle as a TIFR clear write.
        wr(A_TIFR, 8'h03);
        wr(A_OCR0, 8'h20);
        wr(A_TCNT0, 8'h1E);
        rd(A_TCNT0);
        rd(A_TCNT0);
        wr(A_TIFR, 8'h02);
        rd(A_TIFR);
        for (int i = 0; i < 230; i++) rd(A_TCNT0);
        rd(A_TIFR);
        wr(A_TIFR, 8'h02);
        rd(A_TIFR);

        // /1024 counting, reset mid-count, then stopped for 2000 cycles.
        wr(A_TCCR0, 8'h05);
        wr(A_TCNT0, 8'h42);
        for (int i = 0; i < 1500; i++) rd((i % 5 == 0) ? A_TIFR : A_TCNT0);
        reset_cycle();
        for (int i = 0; i < 6; i++) rd(addrs[i]);
        for (int i = 0; i < 2000; i++) rd(A_TCNT0);

        // Randomized traffic.
        for (int i = 0; i < 6000; i++) begin
            int r;
            bit c, ao, ac, w;
            logic [5:0] a;
            logic [7:0] d;
            r = $urandom_range(0, 99);
            c = ($urandom_range(0, 999) < 3);
            ao = ($urandom_range(0, 19) == 0);
            ac = ($urandom_range(0, 19) == 0);
            w = 1'b1;
            d = 8'($urandom_range(0, 255));
            if (r < 3) begin
                a = A_TCCR0;
                if ($urandom_range(0, 3) != 0) d[2:0] = 3'($urandom_range(1, 3));
            end else if (r < 8) begin
                a = A_OCR0;
            end else if (r < 12) begin
                a = A_TCNT0;
                if ($urandom_range(0, 1) == 1) d = 8'(m_ocr + $urandom_range(0, 2));
            end else if (r < 15) begin
                a = A_TIMSK;
            end else if (r < 19) begin
                a = A_TIFR;
            end else begin
                w = 1'b0;
                a = addrs[$urandom_range(0, 5)];
            end
            drive(c, a, w, d, ao, ac);
        end

        // Drain the scoreboard (bounded) and report.
        rd(A_NONE);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
